uart_mmio: RTL



---
 rtl/uart_mmio.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped front end for the uart block.
// Buffers outgoing bytes in a TX FIFO feeding send_req, and incoming bytes
// from recv_rsp in an RX FIFO. Software sees STATUS/CTRL (0x0), TX_DATA (0x4)
// and RX_DATA (0x8). Overflow and drop events are held in sticky flags.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   req_valid/we/addr/wdata      MMIO access (byte offset, bits [1:0] ignored)
//   rsp_valid, rsp_rdata         registered read response, one cycle after a read
//   send_req_valid/ready/data    byte stream to uart (valid = TX FIFO not empty)
//   recv_rsp_valid/ready/data    byte stream from uart (ready = not in reset)
module uart_mmio #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        send_req_valid,
    input  logic        send_req_ready,
    output logic [7:0]  send_req_data,
    input  logic        recv_rsp_valid,
    output logic        recv_rsp_ready,
    input  logic [7:0]  recv_rsp_data
);

    localparam int unsigned   PW         = $clog2(DEPTH);
    localparam int unsigned   CW         = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] SEL_STATUS = 2'd0;
    localparam logic [1:0] SEL_TX     = 2'd1;
    localparam logic [1:0] SEL_RX     = 2'd2;

    // Request decode (word select only)
    logic [1:0] reg_sel;
    logic       wr_en;
    logic       rd_en;
    logic       status_wr;

    assign reg_sel   = req_addr[3:2];
    assign wr_en     = req_valid & req_we;
    assign rd_en     = req_valid & ~req_we;
    assign status_wr = wr_en && (reg_sel == SEL_STATUS);

    // Byte-offset low bits and upper write-data bits carry no meaning here
    logic unused_bits;
    assign unused_bits = &{1'b0, req_addr[1:0], req_wdata[31:10]};

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] tx_rd_ptr;
    logic [PW-1:0] tx_wr_ptr;
    logic [CW-1:0] tx_count;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_push;
    logic          tx_push_ok;
    logic          tx_pop;
    logic          tx_flush;

    assign tx_full    = (tx_count == FULL_COUNT);
    assign tx_empty   = (tx_count == '0);
    assign tx_push    = wr_en && (reg_sel == SEL_TX);
    assign tx_push_ok = tx_push & ~tx_full;
    assign tx_pop     = ~tx_empty & send_req_ready;
    assign tx_flush   = status_wr & req_wdata[8];

    assign send_req_valid = ~tx_empty;
    assign send_req_data  = tx_mem[tx_rd_ptr];

    // TX pointers and occupancy; flush overrides same-cycle push/pop
    always_ff @(posedge clk) begin
        if (rst || tx_flush) begin
            tx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + PW'(1);
            if (tx_pop)     tx_rd_ptr <= tx_rd_ptr + PW'(1);
            tx_count <= tx_count + CW'(tx_push_ok) - CW'(tx_pop);
        end
    end

    // TX storage
    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem[tx_wr_ptr] <= req_wdata[7:0];
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_rd_ptr;
    logic [PW-1:0] rx_wr_ptr;
    logic [CW-1:0] rx_count;
    logic          rx_full;
    logic          rx_empty;
    logic          rx_push;
    logic          rx_push_ok;
    logic          rx_pop;
    logic          rx_flush;

    // The serial receiver cannot stall, so ready is only withheld in reset
    assign recv_rsp_ready = ~rst;

    assign rx_full    = (rx_count == FULL_COUNT);
    assign rx_empty   = (rx_count == '0);
    assign rx_push    = recv_rsp_valid & recv_rsp_ready;
    assign rx_push_ok = rx_push & ~rx_full;
    assign rx_pop     = rd_en && (reg_sel == SEL_RX) && ~rx_empty;
    assign rx_flush   = status_wr & req_wdata[9];

    // RX pointers and occupancy; flush overrides same-cycle push/pop
    always_ff @(posedge clk) begin
        if (rst || rx_flush) begin
            rx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + PW'(1);
            if (rx_pop)     rx_rd_ptr <= rx_rd_ptr + PW'(1);
            rx_count <= rx_count + CW'(rx_push_ok) - CW'(rx_pop);
        end
    end

    // RX storage
    always_ff @(posedge clk) begin
        if (rx_push_ok) rx_mem[rx_wr_ptr] <= recv_rsp_data;
    end

    // ---------------- Sticky flags ----------------
    logic tx_drop;
    logic rx_ovf;

    // A new event in the same cycle as its W1C keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_drop <= 1'b0;
            rx_ovf  <= 1'b0;
        end else begin
            tx_drop <= (tx_push & tx_full) | (tx_drop & ~(status_wr & req_wdata[5]));
            rx_ovf  <= (rx_push & rx_full) | (rx_ovf  & ~(status_wr & req_wdata[4]));
        end
    end

    // ---------------- Read path ----------------
    logic [31:0] rdata_next;

    // Read data is taken from pre-update state
    always_comb begin
        rdata_next = '0;
        if (reg_sel == SEL_STATUS) begin
            rdata_next = {8'b0, 8'(rx_count), 8'(tx_count), 2'b0,
                          tx_drop, rx_ovf, rx_full, rx_empty, tx_empty, tx_full};
        end else if ((reg_sel == SEL_RX) && !rx_empty) begin
            rdata_next = {1'b1, 23'b0, rx_mem[rx_rd_ptr]};
        end
    end

    // Response register; data holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= rd_en;
            if (rd_en) rsp_rdata <= rdata_next;
        end
    end

endmodule
